// File: rtl/seg7_mmio_display.sv
// Memory-mapped 4-digit hex seven-segment display (DATA/CTRL registers, time-multiplexed scan).
// Latency: register write/read takes effect at the next edge; pins are registered, 1 cycle behind scan state.
// Backpressure: none; every bus access completes in one cycle. Optional SEG_LZB_EN enables leading-zero blanking.
module seg7_mmio_display #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] write_address,
   input  logic [31:0] write_data,
   input  logic        mem_read,
   input  logic [31:0] read_address,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        seg_c1,
   output logic        seg_c2,
   output logic        seg_c3,
   output logic        seg_c4,
   output logic        seg_a,
   output logic        seg_b,
   output logic        seg_c,
   output logic        seg_d,
   output logic        seg_e,
   output logic        seg_f,
   output logic        seg_g,
   output logic        seg_h
);

   // Word addresses of the two registers; byte-offset bits are ignored on the bus.
   localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
   localparam logic [29:0] DATA_WA   = BASE_ADDR[31:2];
   localparam logic [29:0] CTRL_WA   = CTRL_ADDR[31:2];
   // Last prescaler value of the visible part of a slot; the following value is the gap cycle.
   localparam logic [CNT_W-1:0] PRE_GAP = CNT_W'(SCAN_DIV - 2);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   logic [15:0]      data_q;
   logic             ctrl_en_q;
   logic [3:0]       dp_mask_q;
   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] pre_q, pre_d;
   logic [1:0]       idx_q, idx_d;
   logic             wr_data_hit, wr_ctrl_hit, rd_data_hit, rd_ctrl_hit;
   logic [3:0]       nibble;
   logic [6:0]       glyph;      // active-high, bit 6 = a ... bit 0 = g
   logic [6:0]       decoded;
   logic [3:0]       digit_sel;  // active-low, bit 3 = c1
   logic             digit_on;
   logic [3:0]       digit_n_q;
   logic [6:0]       seg_n_q;
   logic             dp_n_q;
   logic             unused_bits;

   assign wr_data_hit = mem_write && (write_address[31:2] == DATA_WA);
   assign wr_ctrl_hit = mem_write && (write_address[31:2] == CTRL_WA);
   assign rd_data_hit = mem_read  && (read_address[31:2]  == DATA_WA);
   assign rd_ctrl_hit = mem_read  && (read_address[31:2]  == CTRL_WA);

   // Upper data bits and byte offsets carry no meaning for this peripheral.
   assign unused_bits = ^{write_data[31:16], write_address[1:0], read_address[1:0]};

   // Register file: full-word stores, unimplemented bits dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q    <= 16'h0000;
         ctrl_en_q <= 1'b0;
         dp_mask_q <= 4'h0;
      end else begin
         if (wr_data_hit) data_q <= write_data[15:0];
         if (wr_ctrl_hit) begin
            ctrl_en_q <= write_data[0];
            dp_mask_q <= write_data[7:4];
         end
      end
   end

   // Read port: a hit returns the pre-edge register value; a miss keeps the last data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data  <= 32'h0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_data_hit || rd_ctrl_hit;
         if (rd_data_hit)      rd_data <= {16'h0000, data_q};
         else if (rd_ctrl_hit) rd_data <= {24'h0, dp_mask_q, 3'b000, ctrl_en_q};
      end
   end

   // Scan state, prescaler and digit index registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_OFF;
         pre_q   <= '0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
      end
   end

   // Scan next-state: dropping EN parks everything; GAP closes each slot and advances the digit.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      idx_d   = idx_q;
      if (!ctrl_en_q) begin
         state_d = ST_OFF;
         pre_d   = '0;
         idx_d   = 2'd0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_SHOW;
               pre_d   = '0;
               idx_d   = 2'd0;
            end
            ST_SHOW: begin
               pre_d = pre_q + CNT_W'(1);
               if (pre_q == PRE_GAP) state_d = ST_GAP;
            end
            ST_GAP: begin
               state_d = ST_SHOW;
               pre_d   = '0;
               idx_d   = idx_q + 2'd1;
            end
            default: begin
               state_d = ST_OFF;
               pre_d   = '0;
               idx_d   = 2'd0;
            end
         endcase
      end
   end

   // Pick the nibble and enable for the current slot; idx 0 is the leftmost digit.
   always_comb begin
      nibble    = data_q[15:12];
      digit_sel = 4'b0111;
      case (idx_q)
         2'd0: begin nibble = data_q[15:12]; digit_sel = 4'b0111; end
         2'd1: begin nibble = data_q[11:8];  digit_sel = 4'b1011; end
         2'd2: begin nibble = data_q[7:4];   digit_sel = 4'b1101; end
         default: begin nibble = data_q[3:0]; digit_sel = 4'b1110; end
      endcase
   end

   // Hex to segment pattern, active-high in a..g order.
   always_comb begin
      decoded = 7'h00;
      case (nibble)
         4'h0: decoded = 7'h7E;
         4'h1: decoded = 7'h30;
         4'h2: decoded = 7'h6D;
         4'h3: decoded = 7'h79;
         4'h4: decoded = 7'h33;
         4'h5: decoded = 7'h5B;
         4'h6: decoded = 7'h5F;
         4'h7: decoded = 7'h70;
         4'h8: decoded = 7'h7F;
         4'h9: decoded = 7'h7B;
         4'hA: decoded = 7'h77;
         4'hB: decoded = 7'h1F;
         4'hC: decoded = 7'h4E;
         4'hD: decoded = 7'h3D;
         4'hE: decoded = 7'h4F;
         default: decoded = 7'h47;
      endcase
   end

`ifdef SEG_LZB_EN
   // Blank a digit when it and everything to its left are zero; the rightmost digit always shows.
   always_comb begin
      glyph = decoded;
      case (idx_q)
         2'd0: if (data_q[15:12] == 4'h0) glyph = 7'h00;
         2'd1: if (data_q[15:8] == 8'h00) glyph = 7'h00;
         2'd2: if (data_q[15:4] == 12'h000) glyph = 7'h00;
         default: glyph = decoded;
      endcase
   end
`else
   assign glyph = decoded;
`endif

   assign digit_on = ctrl_en_q && (state_q == ST_SHOW);

   // Pin registers: light one digit during SHOW, everything dark when off or in the gap cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit_n_q <= 4'hF;
         seg_n_q   <= 7'h7F;
         dp_n_q    <= 1'b1;
      end else if (digit_on) begin
         digit_n_q <= digit_sel;
         seg_n_q   <= ~glyph;
         dp_n_q    <= ~dp_mask_q[idx_q];
      end else begin
         digit_n_q <= 4'hF;
         seg_n_q   <= 7'h7F;
         dp_n_q    <= 1'b1;
      end
   end

   assign {seg_c1, seg_c2, seg_c3, seg_c4} = digit_n_q;
   assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_n_q;
   assign seg_h = dp_n_q;

endmodule
